// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide sequencer that owns the HI/LO register pair.
// Ports: clk, rst (sync, active-high); start/op/src_a/src_b launch
//   MULT/MULTU/DIV/DIVU; mf_req/mf_sel read HI or LO onto mf_data;
//   busy/stall/done report progress; hi/lo expose the registers.
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             mf_req,
   input  logic             mf_sel,
   output logic [WIDTH-1:0] mf_data,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      PREP,
      RUN,
      FIX
   } state_t;

   state_t state, state_nx;

   logic [1:0]       op_r;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] a_raw;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] low;
   logic             sa;
   logic             sb;
   logic [CW-1:0]    cnt;

   logic             is_div;
   logic             is_uns;
   logic             sign_a;
   logic             sign_b;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic [WIDTH:0]   add_sum;
   logic [WIDTH:0]   shl;
   logic [WIDTH:0]   sub;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_neg;

   assign is_div = op_r[1];
   assign is_uns = op_r[0];

   // Negating the most negative value wraps to itself, which reads
   // correctly as the unsigned magnitude 2^(WIDTH-1).
   assign sign_a = ~is_uns & opa[WIDTH-1];
   assign sign_b = ~is_uns & opb[WIDTH-1];
   assign mag_a  = sign_a ? -opa : opa;
   assign mag_b  = sign_b ? -opb : opb;

   // Multiply step: carry out of the add shifts into the upper half.
   assign add_sum = {1'b0, acc} + {1'b0, opa};

   // Divide step: bit WIDTH of the difference is the borrow.
   assign shl = {acc, low[WIDTH-1]};
   assign sub = shl - {1'b0, opb};

   assign prod     = {acc, low};
   assign prod_neg = -prod;

   assign busy    = (state != IDLE);
   assign stall   = (start | mf_req) & busy;
   assign done    = (state == FIX);
   assign mf_data = mf_sel ? hi : lo;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (start) state_nx = PREP;
         PREP: state_nx = RUN;
         RUN:  if (cnt == '0) state_nx = FIX;
         FIX:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_r  <= '0;
         opa   <= '0;
         opb   <= '0;
         a_raw <= '0;
         acc   <= '0;
         low   <= '0;
         sa    <= 1'b0;
         sb    <= 1'b0;
         cnt   <= '0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  op_r  <= op;
                  opa   <= src_a;
                  opb   <= src_b;
                  a_raw <= src_a;
               end
            end
            PREP: begin
               sa  <= sign_a;
               sb  <= sign_b;
               opa <= mag_a;
               opb <= mag_b;
               acc <= '0;
               low <= is_div ? mag_a : mag_b;
               cnt <= CW'(WIDTH - 1);
            end
            RUN: begin
               if (cnt != '0) cnt <= cnt - CW'(1);
               if (is_div) begin
                  if (!sub[WIDTH]) begin
                     acc <= sub[WIDTH-1:0];
                     low <= {low[WIDTH-2:0], 1'b1};
                  end else begin
                     acc <= shl[WIDTH-1:0];
                     low <= {low[WIDTH-2:0], 1'b0};
                  end
               end else begin
                  if (low[0]) begin
                     acc <= add_sum[WIDTH:1];
                     low <= {add_sum[0], low[WIDTH-1:1]};
                  end else begin
                     acc <= {1'b0, acc[WIDTH-1:1]};
                     low <= {acc[0], low[WIDTH-1:1]};
                  end
               end
            end
            FIX: begin
               if (!is_div) begin
                  if (sa ^ sb) {hi, lo} <= prod_neg;
                  else         {hi, lo} <= prod;
               end else if (opb == '0) begin
                  // Divide by zero: divisor magnitude is zero only
                  // when the latched divisor was zero.
                  hi <= a_raw;
                  lo <= '1;
               end else begin
                  lo <= (sa ^ sb) ? -low : low;
                  hi <= sa ? -acc : acc;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table through a
// scoreboard, plus stall, back-to-back and reset-abort sequences.
module tb_muldiv_sequencer;

   localparam logic [1:0] MULT  = 2'b00;
   localparam logic [1:0] MULTU = 2'b01;
   localparam logic [1:0] DIV   = 2'b10;
   localparam logic [1:0] DIVU  = 2'b11;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        mf_req;
   logic        mf_sel;
   logic [31:0] mf_data;
   logic        busy;
   logic        stall;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   muldiv_sequencer #(.WIDTH(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .op      (op),
      .src_a   (src_a),
      .src_b   (src_b),
      .mf_req  (mf_req),
      .mf_sel  (mf_sel),
      .mf_data (mf_data),
      .busy    (busy),
      .stall   (stall),
      .done    (done),
      .hi      (hi),
      .lo      (lo)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          acc;
   } exp_t;

   exp_t sbq[$];
   vec_t tbl[12];

   int total = 0;
   int bad = 0;

   task automatic check(input string name,
                        input logic [63:0] act,
                        input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      total++;
      bad++;
      $display("FAIL %s timeout at cycle %0d", name, cyc);
   endtask

   task automatic run_op(input logic [1:0] o,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [31:0] eh,
                         input logic [31:0] el,
                         input bit push,
                         output int acc_cyc);
      int n;
      @(negedge clk);
      op    = o;
      src_a = a;
      src_b = b;
      start = 1'b1;
      n = 0;
      while (busy !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) timeout("accept");
      @(posedge clk);
      #1;
      start = 1'b0;
      acc_cyc = cyc;
      if (push) sbq.push_back('{eh, el, cyc});
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sbq.size() != 0) timeout("drain");
   endtask

   // Scoreboard: on each done, compare HI/LO after the update edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            @(posedge clk);
            #1;
            if (sbq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done at cycle %0d", cyc);
            end else begin
               e = sbq.pop_front();
               check("hi", 64'(hi), 64'(e.hi));
               check("lo", 64'(lo), 64'(e.lo));
               check("latency", 64'(cyc - e.acc), 64'd34);
            end
         end
      end
   end

   initial begin
      int a1;
      int a2;
      int n;

      tbl[0]  = '{MULTU, 32'hFFFFFFFF, 32'h2, 32'h1, 32'hFFFFFFFE};
      tbl[1]  = '{MULT, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE};
      tbl[2]  = '{MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0};
      tbl[3]  = '{DIV, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD};
      tbl[4]  = '{DIVU, 32'h7, 32'h2, 32'h1, 32'h3};
      tbl[5]  = '{DIVU, 32'h1234, 32'h0, 32'h1234, 32'hFFFFFFFF};
      tbl[6]  = '{DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000};
      tbl[7]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1};
      tbl[8]  = '{MULT, 32'hFFFFFFFD, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFF1};
      tbl[9]  = '{DIV, 32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD};
      tbl[10] = '{DIVU, 32'h64, 32'h7, 32'h2, 32'hE};
      tbl[11] = '{DIV, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF};

      rst    = 1'b1;
      start  = 1'b0;
      op     = 2'b00;
      src_a  = '0;
      src_b  = '0;
      mf_req = 1'b0;
      mf_sel = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);

      // Vector table, issued back-to-back.
      for (int i = 0; i < 12; i++) begin
         run_op(tbl[i].op, tbl[i].a, tbl[i].b,
                tbl[i].hi, tbl[i].lo, 1'b1, a1);
      end
      drain();

      // Second start while busy waits for the cycle after FIX.
      run_op(MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b1, a1);
      run_op(DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 1'b1, a2);
      check("b2b_gap", 64'(a2 - a1), 64'd35);
      drain();

      // HI/LO read held against an operation in flight.
      run_op(MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b1, a1);
      mf_req = 1'b1;
      mf_sel = 1'b0;
      n = 0;
      @(negedge clk);
      while (stall === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("mf_stall_cycles", 64'(n), 64'd34);
      check("mf_busy", 64'(busy), 64'd0);
      check("mf_data", 64'(mf_data), 64'd15);
      mf_req = 1'b0;
      drain();

      // Start and read together in IDLE: no stall, old LO returned.
      @(negedge clk);
      op     = MULTU;
      src_a  = 32'd2;
      src_b  = 32'd2;
      start  = 1'b1;
      mf_req = 1'b1;
      mf_sel = 1'b0;
      #1;
      check("co_stall", 64'(stall), 64'd0);
      check("co_mf_data", 64'(mf_data), 64'd15);
      @(posedge clk);
      #1;
      start  = 1'b0;
      mf_req = 1'b0;
      sbq.push_back('{32'd0, 32'd4, cyc});
      drain();

      // Reset during RUN: abort, clear, and never pulse done.
      run_op(MULTU, 32'd6, 32'd7, 32'd0, 32'd0, 1'b0, a1);
      repeat (11) @(negedge clk);
      check("abort_in_run", 64'(busy), 64'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_hi", 64'(hi), 64'd0);
      check("abort_lo", 64'(lo), 64'd0);
      repeat (50) @(negedge clk);
      check("abort_idle", 64'(busy), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
